// File: rtl/gf2_mul_pkg.sv
// Shared constants and state encoding for the digit-serial
// GF(2) polynomial multiplier.
package gf2_mul_pkg;

    localparam int N    = 71;
    localparam int D    = 8;
    localparam int NDIG = (N + D - 1) / D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gf2_mul_71x8.sv
// Combinational carry-less product of an N-bit operand and
// a D-bit digit; result is N+D-1 bits wide.
module gf2_mul_71x8 #(
    parameter int N = 71,
    parameter int D = 8
) (
    input  logic [N-1:0]   a,
    input  logic [D-1:0]   b,
    output logic [N+D-2:0] p
);

    logic [N+D-2:0] a_ext;

    assign a_ext = {{(D-1){1'b0}}, a};

    always_comb begin
        p = '0;
        for (int j = 0; j < D; j++) begin
            if (b[j]) begin
                p = p ^ (a_ext << j);
            end
        end
    end

endmodule

// File: rtl/gf2_mul_71bit_serial.sv
// Digit-serial carry-less multiplier: B is consumed D bits per cycle,
// MSB digit first, accumulating Horner-style into a 2N-1 bit register.
module gf2_mul_71bit_serial
    import gf2_mul_pkg::*;
#(
    parameter int N = gf2_mul_pkg::N,
    parameter int D = gf2_mul_pkg::D
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] c_out,
    output logic           busy
);

    localparam int ND = (N + D - 1) / D;
    localparam int BW = ND * D;
    localparam int W  = 2 * N - 1;
    localparam int P  = N + D - 1;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;

    state_t        state;
    logic [N-1:0]  a_q;
    logic [BW-1:0] b_q;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;

    logic [D-1:0]  digit;
    logic [P-1:0]  prod;
    logic [W-1:0]  prod_ext;
    logic [W-1:0]  acc_next;

    assign digit    = b_q[int'(cnt) * D +: D];
    assign prod_ext = {{(W - P){1'b0}}, prod};
    // Bits pushed past the top are always zero for a valid product.
    assign acc_next = (acc << D) ^ prod_ext;

    gf2_mul_71x8 #(
        .N (N),
        .D (D)
    ) u_digit_mul (
        .a (a_q),
        .b (digit),
        .p (prod)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            c_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a_in;
                        b_q   <= {{(BW - N){1'b0}}, b_in};
                        acc   <= '0;
                        cnt   <= CW'(ND - 1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (cnt == '0) begin
                        c_out     <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2_mul_71bit_serial.sv
// Scoreboard bench for the digit-serial GF(2) multiplier: a driver pushes
// expected products, a negedge monitor pops and compares on each result.
module tb_gf2_mul_71bit_serial;

    localparam int N   = 71;
    localparam int W   = 2 * N - 1;
    localparam int LAT = 10;

    typedef struct {
        logic [W-1:0] v;
        int           e;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a_in = '0;
    logic [N-1:0] b_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] c_out;
    logic         busy;

    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;
    bit   rdy_rand = 1'b0;
    exp_t exp_q[$];

    gf2_mul_71bit_serial #(.N(N), .D(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    function automatic logic [W-1:0] ref_mul(logic [N-1:0] a, logic [N-1:0] b);
        logic [W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (a[i] && b[j]) c[i+j] = ~c[i+j];
        return c;
    endfunction

    function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    function automatic logic [N-1:0] rnd71();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(logic [N-1:0] a, logic [N-1:0] b, logic [W-1:0] req);
        int g;
        exp_t x;
        step();
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 200) begin
            step();
            g++;
        end
        if (!in_ready) begin
            chk("accept_timeout", W'(in_ready), W'(1));
        end else begin
            x.v = req;
            x.e = edge_cnt + 1;
            exp_q.push_back(x);
        end
        step();
        in_valid = 1'b0;
    endtask

    // Random backpressure while enabled.
    always @(negedge clk) begin
        if (rdy_rand) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor.
    logic [W-1:0] held;
    bit           ov_prev = 1'b0;
    exp_t         cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", W'(out_valid), W'(0));
                end else begin
                    cur = exp_q.pop_front();
                    chk("product", c_out, cur.v);
                    chk("latency", W'(edge_cnt - cur.e + 1), W'(LAT));
                end
                held = c_out;
            end else if (out_valid && ov_prev) begin
                chk("done_stable", c_out, held);
            end else if (!out_valid && ov_prev) begin
                chk("drop_needs_ready", W'(out_ready), W'(1));
                chk("c_out_hold", c_out, held);
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [W-1:0] req;
        int g;

        #2;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_c_out", c_out, '0);
        chk("rst_busy", W'(busy), W'(0));
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", W'(in_ready), W'(1));

        // Directed products.
        send(71'd1, 71'd1, 141'd1);
        send(71'h3, 71'h3, 141'h5);
        a = '1;
        req = '0;
        req[0]  = 1'b1;
        req[71] = 1'b1;
        send(a, 71'h3, req);
        a = '0;
        a[70] = 1'b1;
        req = '0;
        req[140] = 1'b1;
        send(a, a, req);

        // Random products with random backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            a = rnd71();
            b = rnd71();
            if (i % 5 == 0) b[N-1] = 1'b1;
            send(a, b, ref_mul(a, b));
        end
        rdy_rand = 1'b0;
        step();
        out_ready = 1'b1;
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 500) begin
            step();
            g++;
        end
        chk("drain1", W'(exp_q.size()), W'(0));

        // Hold DONE with out_ready low; pulses must be ignored.
        out_ready = 1'b0;
        a = rnd71();
        b = rnd71();
        send(a, b, ref_mul(a, b));
        g = 0;
        while (!out_valid && g < 50) begin
            step();
            g++;
        end
        chk("done_reached", W'(out_valid), W'(1));
        for (int i = 0; i < 5; i++) begin
            a_in     = rnd71();
            b_in     = rnd71();
            in_valid = 1'b1;
            chk("done_no_ready", W'(in_ready), W'(0));
            chk("done_busy", W'(busy), W'(1));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("after_done_valid", W'(out_valid), W'(0));
        chk("after_done_ready", W'(in_ready), W'(1));
        send(71'h3, 71'h3, 141'h5);
        repeat (LAT + 2) step();

        // Reset in the middle of RUN.
        a = rnd71();
        b = rnd71();
        send(a, b, ref_mul(a, b));
        repeat (3) step();
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_c_out", c_out, '0);
        chk("midrst_busy", W'(busy), W'(0));
        repeat (2) step();
        rst_n = 1'b1;
        repeat (15) step();
        chk("midrst_no_pulse", c_out, '0);
        send(71'h3, 71'h3, 141'h5);
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 100) begin
            step();
            g++;
        end
        chk("drain2", W'(exp_q.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gf2_mul_71bit_serial.md
GF2_MUL_71BIT_SERIAL -- requirements
Module: gf2_mul_71bit_serial

Interface
REQ-001 SHALL have parameter N, default 71, operand width in bits (the half-operand of the 142-bit Karatsuba level).
REQ-002 SHALL have parameter D, default 8, digit width consumed per cycle.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a_in  input  N  operand A, polynomial over GF(2), bit i = coefficient of x^i.
REQ-008 b_in  input  N  operand B, same encoding.
REQ-009 out_valid  output  1  c_out holds a completed product.
REQ-010 out_ready  input  1  consumer accepts c_out.
REQ-011 c_out  output  2N-1  carry-less product A*B over GF(2); 141 bits at default.
REQ-012 busy  output  1  high in RUN and DONE.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE SHALL be ignored.
REQ-015 On an edge in IDLE with in_valid=1: capture a_in, and b_in zero-padded to NDIG*D bits with NDIG=ceil(N/D) (9 at default); clear accumulator; set digit counter to NDIG-1; enter RUN.
REQ-016 Each RUN edge SHALL compute acc <= (acc << D) XOR (A * b_digit[cnt]), carry-less, MSB digit first (Horner), then decrement cnt.
REQ-017 The accumulator SHALL be 2N-1 bits; bits shifted above bit 2N-2 SHALL be discarded (they are always 0 for a valid product).
REQ-018 The RUN edge with cnt=0 SHALL load c_out with the final accumulator, set out_valid=1 and enter DONE.
REQ-019 Latency SHALL be exactly NDIG+1 edges from the accept edge to out_valid=1 (10 at default).
REQ-020 In DONE, c_out and out_valid SHALL hold stable until an edge with out_ready=1; that edge SHALL clear out_valid and enter IDLE (in_ready=1 the next cycle; no same-cycle re-accept).
REQ-021 c_out SHALL hold the last product after leaving DONE until the next completion overwrites it.
REQ-022 Operand register contents SHALL NOT change while in RUN or DONE.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, in_ready=1 after deassertion, out_valid=0, busy=0, c_out=0, accumulator=0, counter=0.
REQ-024 Reset during RUN or DONE SHALL abort the operation with no output pulse; the first post-reset accept SHALL start a fresh computation.

Structure
REQ-025 Shared package gf2_mul_pkg SHALL hold N, D, NDIG and the state enum (IDLE, RUN, DONE).
REQ-026 Carry-less A x digit product SHALL be a combinational sub-module gf2_mul_71x8 (N-bit by D-bit, N+D-1-bit result); all registers stay in the top module.

Verification
REQ-027 a=1, b=1 -> out_valid exactly 10 edges after accept, c_out=1.
REQ-028 a=0x3, b=0x3 -> c_out=0x5 (carry-less (x+1)^2 = x^2+1).
REQ-029 a=all ones (71 bits), b=0x3 -> c_out has only bits 0 and 71 set.
REQ-030 a=x^70, b=x^70 -> c_out has only bit 140 set.
REQ-031 out_ready held low 5 cycles in DONE -> c_out and out_valid stable throughout; in_valid pulses during that window are not accepted; accept after return to IDLE.
REQ-032 rst_n asserted at RUN cycle 4 -> out_valid never asserts, c_out=0; a new pair (a=0x3, b=0x3) afterwards yields 0x5 at normal latency.
